// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory/IO bus between the instruction fetch port and the data port.
// The data port has priority. After MAX_WAIT data grants in a row while fetch is
// waiting, fetch is forced next. A grant that sees no bus_ack for TIMEOUT cycles is
// aborted with a ready pulse, zero read data and tmo_err.
// Every transaction is followed by one IDLE turnaround cycle. A requester can
// therefore drop or change its request after it sees ready.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | bus released; arbitration decision registered for next cycle
// GNT_I | fetch port owns the bus; bus_req held until ack or timeout
// GNT_D | data port owns the bus; bus_req held until ack or timeout

module mem_bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_ready,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [1:0]    d_wl,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,

    output logic          bus_req,
    output logic          bus_we,
    output logic [1:0]    bus_wl,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic [DW-1:0] bus_rdata,
    input  logic          bus_ack,

    output logic          stall_if,
    output logic          stall_mem,
    output logic          tmo_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);

    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [1:0]    WL_WORD    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_nxt;
    logic [TW-1:0] tmo_cnt;
    logic [TW-1:0] tmo_nxt;
    logic          load_i;
    logic          load_d;
    logic          gnt_done;
    logic          tmo_hit;

    // State and arbitration counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            tmo_cnt    <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            tmo_cnt    <= tmo_nxt;
        end
    end

    // Next-state logic: arbitration in IDLE, then ack/timeout completion in the grant states.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        tmo_nxt    = tmo_cnt;
        load_i     = 1'b0;
        load_d     = 1'b0;
        gnt_done   = 1'b0;
        tmo_hit    = 1'b0;
        case (state)
            IDLE: begin
                tmo_nxt = '0;
                if (d_req && ((starve_cnt < STARVE_MAX) || !if_req)) begin
                    state_nxt = GNT_D;
                    load_d    = 1'b1;
                    if (!if_req) begin
                        starve_nxt = '0;
                    end else if (starve_cnt != STARVE_MAX) begin
                        starve_nxt = starve_cnt + SW'(1);
                    end
                end else if (if_req) begin
                    state_nxt  = GNT_I;
                    load_i     = 1'b1;
                    starve_nxt = '0;
                end else begin
                    starve_nxt = '0;
                end
            end
            GNT_I, GNT_D: begin
                // An ack in the expiry cycle counts as a normal completion.
                if (bus_ack) begin
                    gnt_done  = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    gnt_done  = 1'b1;
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = tmo_cnt + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the granted port's request on grant entry. The bus then stays stable for the whole grant.
    // A fetch puts zero on the write-data lines because it has no write data of its own.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_we    <= 1'b0;
            bus_wl    <= 2'b00;
            bus_addr  <= '0;
            bus_wdata <= '0;
        end else if (load_d) begin
            bus_we    <= d_we;
            bus_wl    <= d_wl;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
        end else if (load_i) begin
            bus_we    <= 1'b0;
            bus_wl    <= WL_WORD;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
        end
    end

    // Port handshakes. Both come straight from the current grant and bus_ack, so they need no extra cycle.
    always_comb begin
        bus_req   = (state == GNT_I) || (state == GNT_D);
        if_ready  = (state == GNT_I) && gnt_done;
        d_ready   = (state == GNT_D) && gnt_done;
        if_rdata  = ((state == GNT_I) && bus_ack) ? bus_rdata : '0;
        d_rdata   = ((state == GNT_D) && bus_ack) ? bus_rdata : '0;
        tmo_err   = tmo_hit;
        stall_if  = if_req && !if_ready;
        stall_mem = d_req && !d_ready;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Directed scenarios followed by a randomized run. Every cycle is compared against a
// transaction-level reference model. The model tracks who owns the bus, how long the
// grant has lasted, and how many data grants fetch has lost in a row.

module tb_mem_bus_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;
    localparam int TIMEOUT  = 15;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          d_req;
    logic          d_we;
    logic [1:0]    d_wl;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          bus_req;
    logic          bus_we;
    logic [1:0]    bus_wl;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          stall_if;
    logic          stall_mem;
    logic          tmo_err;

    int total = 0;
    int bad   = 0;

    mem_bus_arbiter #(
        .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_wl(d_wl), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_wl(bus_wl), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .stall_if(stall_if), .stall_mem(stall_mem), .tmo_err(tmo_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model. owner: 0 none, 1 fetch, 2 data.
    int          m_owner;
    int          m_cycles;
    int          m_lost;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_we;
    logic [1:0]  m_wl;

    logic        e_bus_req, e_if_ready, e_d_ready, e_tmo, e_fin, e_drd_care;
    logic [31:0] e_if_rdata, e_d_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_cycles = 0;
        m_lost   = 0;
        m_addr   = '0;
        m_wdata  = '0;
        m_we     = 1'b0;
        m_wl     = 2'b00;
    endtask

    // Expected outputs for the current cycle, given the inputs now applied.
    task automatic model_eval();
        if (!rst) model_reset();
        e_bus_req  = (m_owner != 0);
        e_fin      = 1'b0;
        e_tmo      = 1'b0;
        e_if_ready = 1'b0;
        e_d_ready  = 1'b0;
        e_if_rdata = '0;
        e_d_rdata  = '0;
        e_drd_care = 1'b1;
        if (m_owner != 0) begin
            e_fin = bus_ack || (m_cycles + 1 == TIMEOUT);
            e_tmo = e_fin && !bus_ack;
            if (m_owner == 1) begin
                e_if_ready = e_fin;
                e_if_rdata = bus_ack ? bus_rdata : 32'h0;
            end else begin
                e_d_ready  = e_fin;
                e_d_rdata  = bus_ack ? bus_rdata : 32'h0;
                e_drd_care = !(m_we && bus_ack);
            end
        end
    endtask

    // Advance the model across a rising edge, using the inputs that were present at that edge.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (m_owner == 0) begin
            if (d_req && (m_lost < MAX_WAIT || !if_req)) begin
                m_owner  = 2;
                m_cycles = 0;
                m_addr   = d_addr;
                m_we     = d_we;
                m_wl     = d_wl;
                m_wdata  = d_wdata;
                m_lost   = if_req ? ((m_lost < MAX_WAIT) ? m_lost + 1 : MAX_WAIT) : 0;
            end else if (if_req) begin
                m_owner  = 1;
                m_cycles = 0;
                m_addr   = if_addr;
                m_we     = 1'b0;
                m_wl     = 2'b10;
                m_wdata  = '0;
                m_lost   = 0;
            end else begin
                m_lost = 0;
            end
        end else if (e_fin) begin
            m_owner = 0;
        end else begin
            m_cycles++;
        end
    endtask

    // Called shortly after a falling edge, once the inputs are applied: compare every output against the model.
    task automatic settle_check();
        #1;
        model_eval();
        chk("bus_req", bus_req, e_bus_req);
        if (e_bus_req) begin
            chk("bus_addr", bus_addr, m_addr);
            chk("bus_we", bus_we, m_we);
            chk("bus_wl", bus_wl, m_wl);
            chk("bus_wdata", bus_wdata, m_wdata);
        end
        if (!rst) begin
            chk("rst_bus_addr", bus_addr, 0);
            chk("rst_bus_we", bus_we, 0);
            chk("rst_bus_wl", bus_wl, 0);
            chk("rst_bus_wdata", bus_wdata, 0);
        end
        chk("if_ready", if_ready, e_if_ready);
        chk("if_rdata", if_rdata, e_if_rdata);
        chk("d_ready", d_ready, e_d_ready);
        if (e_drd_care) chk("d_rdata", d_rdata, e_d_rdata);
        chk("tmo_err", tmo_err, e_tmo);
        chk("stall_if", stall_if, if_req && !e_if_ready);
        chk("stall_mem", stall_mem, d_req && !e_d_ready);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    int  nd;
    int  nd2;
    logic got_f;
    logic got_f2;

    initial begin
        rst       = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_wl      = 2'b00;
        d_addr    = '0;
        d_wdata   = '0;
        bus_rdata = '0;
        bus_ack   = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset asserted, then released, with no requests pending.
        settle_check();
        chk("t1_rst_bus_req", bus_req, 0);
        chk("t1_rst_tmo", tmo_err, 0);
        tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle_check();
            chk("t1_idle_bus_req", bus_req, 0);
            tick();
        end

        // Fetch at 0x40. The bus acks on the second bus_req cycle.
        if_req = 1'b1; if_addr = 32'h40;
        settle_check();
        chk("t2_c1_stall_if", stall_if, 1);
        chk("t2_c1_bus_req", bus_req, 0);
        tick();
        settle_check();
        chk("t2_c2_bus_req", bus_req, 1);
        chk("t2_c2_addr", bus_addr, 32'h40);
        chk("t2_c2_we", bus_we, 0);
        chk("t2_c2_wl", bus_wl, 2'b10);
        chk("t2_c2_stall_if", stall_if, 1);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h00500093;
        settle_check();
        chk("t2_c3_if_ready", if_ready, 1);
        chk("t2_c3_if_rdata", if_rdata, 32'h00500093);
        chk("t2_c3_stall_if", stall_if, 0);
        tick();

        // Both ports request at once and the bus acks immediately: data goes first.
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000; d_wdata = 32'hDEADBEEF; d_wl = 2'b00;
        bus_ack = 1'b1; bus_rdata = 32'h11112222;
        settle_check();
        chk("t3_idle_bus_req", bus_req, 0);
        tick();
        settle_check();
        chk("t3_d_addr", bus_addr, 32'h1000);
        chk("t3_d_we", bus_we, 1);
        chk("t3_d_wl", bus_wl, 2'b00);
        chk("t3_d_wdata", bus_wdata, 32'hDEADBEEF);
        chk("t3_d_ready", d_ready, 1);
        chk("t3_if_not_ready", if_ready, 0);
        tick();
        d_req = 1'b0;
        settle_check();
        chk("t3_turnaround", bus_req, 0);
        tick();
        settle_check();
        chk("t3_f_addr", bus_addr, 32'h80);
        chk("t3_f_ready", if_ready, 1);
        tick();

        // Data held continuously while fetch waits: four data grants, then fetch. This happens twice.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        nd = 0; got_f = 1'b0;
        for (int k = 0; k < 40 && !got_f; k++) begin
            settle_check();
            if (d_ready) nd++;
            if (if_ready) got_f = 1'b1;
            tick();
        end
        chk("t4_fetch_seen", got_f, 1);
        chk("t4_data_grants", nd, MAX_WAIT);
        nd2 = 0; got_f2 = 1'b0;
        for (int k = 0; k < 40 && !got_f2; k++) begin
            settle_check();
            if (d_ready) nd2++;
            if (if_ready) got_f2 = 1'b1;
            tick();
        end
        chk("t4_fetch_seen2", got_f2, 1);
        chk("t4_data_grants2", nd2, MAX_WAIT);
        if_req = 1'b0; d_req = 1'b0; bus_ack = 1'b0;
        settle_check();
        tick();

        // A data read that never sees an ack times out on grant cycle TIMEOUT.
        d_req = 1'b1; d_we = 1'b0; d_wl = 2'b10; d_addr = 32'h3000;
        bus_rdata = 32'hCAFEF00D;
        settle_check();
        tick();
        for (int g = 1; g <= TIMEOUT; g++) begin
            settle_check();
            if (g < TIMEOUT) begin
                chk("t5_wait_ready", d_ready, 0);
                chk("t5_wait_tmo", tmo_err, 0);
                chk("t5_wait_bus_req", bus_req, 1);
            end else begin
                chk("t5_exp_ready", d_ready, 1);
                chk("t5_exp_rdata", d_rdata, 0);
                chk("t5_exp_tmo", tmo_err, 1);
            end
            tick();
        end
        d_req = 1'b0;
        settle_check();
        chk("t5_after_bus_req", bus_req, 0);
        chk("t5_after_tmo", tmo_err, 0);
        tick();

        // An ack in the expiry cycle completes the read normally, with no tmo_err.
        d_req = 1'b1;
        settle_check();
        tick();
        for (int g = 1; g <= TIMEOUT; g++) begin
            bus_ack = (g == TIMEOUT);
            bus_rdata = 32'h12345678;
            settle_check();
            if (g == TIMEOUT) begin
                chk("t5b_ready", d_ready, 1);
                chk("t5b_rdata", d_rdata, 32'h12345678);
                chk("t5b_tmo", tmo_err, 0);
            end
            tick();
        end
        d_req = 1'b0; bus_ack = 1'b0;
        settle_check();
        tick();

        // Reset asserted in the middle of a data grant.
        d_req = 1'b1; d_addr = 32'h4000;
        settle_check();
        tick();
        settle_check();
        chk("t6_pre_bus_req", bus_req, 1);
        #2;
        rst = 1'b0;
        settle_check();
        chk("t6_rst_bus_req", bus_req, 0);
        chk("t6_rst_bus_addr", bus_addr, 0);
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h200;
        tick();
        rst = 1'b1;
        settle_check();
        chk("t6_idle_bus_req", bus_req, 0);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h0BADC0DE;
        settle_check();
        chk("t6_f_bus_req", bus_req, 1);
        chk("t6_f_addr", bus_addr, 32'h200);
        chk("t6_f_ready", if_ready, 1);
        tick();
        if_req = 1'b0; bus_ack = 1'b0;
        settle_check();
        tick();

        // Randomized traffic. Port fields change every cycle, and ack is withheld in periodic quiet windows.
        for (int n = 0; n < 2400; n++) begin
            if (!if_req || e_if_ready) if_req = ($urandom_range(0, 99) < 55);
            if (!d_req || e_d_ready) d_req = ($urandom_range(0, 99) < 65);
            if_addr   = $urandom;
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_we      = $urandom_range(0, 1) == 1;
            d_wl      = 2'($urandom_range(0, 2));
            bus_rdata = $urandom;
            bus_ack   = ((n % 90) < 60) && ($urandom_range(0, 99) < 40);
            settle_check();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
